mux_n_reg: RTL and testbench

- Parametrised N-channel, WIDTH-bit registered multiplexer. It is the successor to the 2:1 combinational word mux in the CPU datapath.
- Adds a valid/ready handshake on every input and on the output.
- Two modes: select-driven (MODE=0) and round-robin arbitration (MODE=1).
- The output is held in a 2-entry skid buffer, so full throughput survives downstream stalls. Used for writeback/forwarding source selection and for shared-port arbitration.

---
 rtl/cpu_mux_pkg.sv | 13 +
 rtl/mux_skid_buf.sv | 65 ++++++
 rtl/mux_n_reg.sv | 95 +++++++++
 tb/tb_mux_n_reg.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mux_pkg.sv
// Shared definitions for the datapath source-select / arbitration muxes.
// Mode encodings and a width helper that never returns zero.
package cpu_mux_pkg;

    localparam int MUX_MODE_SEL = 0;
    localparam int MUX_MODE_RR  = 1;

    // A 2-channel mux still needs a 1-bit select, so the result is clamped to 1.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_skid_buf.sv
// Two-entry valid/ready skid register: a main output register plus one skid slot.
// Ready is a function of registered state and flush only, so it never waits on out_ready.
module mux_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         live;
    logic         main_vld;
    logic         skid_vld;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;
    logic         in_fire;
    logic         out_fire;

    // live keeps ready low while reset is asserted and for the first edge after release.
    assign in_ready  = live && !skid_vld && !flush;
    assign out_valid = main_vld;
    assign out_data  = main_q;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = main_vld && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live     <= 1'b0;
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            // NOTE: the data registers are reset too, because out_data must read 0 out of reset.
            main_q   <= '0;
            skid_q   <= '0;
        end else begin
            // NOTE: all state here uses <= so every register samples pre-edge values.
            live <= 1'b1;
            if (flush) begin
                main_vld <= 1'b0;
                skid_vld <= 1'b0;
            end else if (skid_vld) begin
                if (out_fire) begin
                    main_q   <= skid_q;
                    skid_vld <= 1'b0;
                end
            end else if (in_fire) begin
                if (!main_vld || out_fire) begin
                    main_q   <= in_data;
                    main_vld <= 1'b1;
                end else begin
                    skid_q   <= in_data;
                    skid_vld <= 1'b1;
                end
            end else if (out_fire) begin
                main_vld <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_n_reg.sv
// N-channel registered word mux with valid/ready on every port.
// Grant comes from sel (MODE 0) or a round-robin search (MODE 1); output sits in a skid buffer.
module mux_n_reg
    import cpu_mux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NCH   = 4,
    parameter int MODE  = MUX_MODE_SEL,
    parameter int SELW  = clog2_min1(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_ch,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic [WIDTH-1:0]      ch_data [NCH];
    logic [SELW-1:0]       ptr;
    logic [SELW-1:0]       gnt;
    logic                  gnt_vld;
    logic                  buf_ready;
    logic                  push;
    logic                  accept;
    logic [SELW+WIDTH-1:0] buf_out;

    for (genvar k = 0; k < NCH; k++) begin : g_unpack
        assign ch_data[k] = in_data[k*WIDTH +: WIDTH];
    end

    always_comb begin
        // NOTE: defaults first, so no path through this block can infer a latch.
        gnt     = '0;
        gnt_vld = 1'b0;
        if (MODE == MUX_MODE_RR) begin
            for (int i = 0; i < NCH; i++) begin
                int              s;
                logic [SELW-1:0] idx;
                s = int'(ptr) + i;
                if (s >= NCH) s = s - NCH;
                idx = SELW'(s);
                if (!gnt_vld && in_valid[idx]) begin
                    gnt     = idx;
                    gnt_vld = 1'b1;
                end
            end
        end else if (int'(sel) < NCH) begin
            gnt     = sel;
            gnt_vld = 1'b1;
        end
    end

    always_comb begin
        in_ready = '0;
        if (gnt_vld) in_ready[gnt] = buf_ready;
    end

    assign push   = gnt_vld && in_valid[gnt];
    assign accept = push && buf_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (flush) begin
            ptr <= '0;
        end else if (MODE == MUX_MODE_RR && accept) begin
            ptr <= (int'(gnt) == NCH - 1) ? '0 : gnt + SELW'(1);
        end
    end

    // Channel index travels with the word so out_ch always names its source.
    mux_skid_buf #(
        .W(SELW + WIDTH)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (push),
        .in_ready (buf_ready),
        .in_data  ({gnt, ch_data[gnt]}),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (buf_out)
    );

    assign out_ch   = buf_out[SELW+WIDTH-1:WIDTH];
    assign out_data = buf_out[WIDTH-1:0];

endmodule

// File: tb/tb_mux_n_reg.sv
// Directed bench for mux_n_reg: select mode (NCH 4 and 3) and round-robin mode,
// with a scoreboard queue per data-carrying instance.
module tb_mux_n_reg;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // a: MODE 0, NCH 4
    logic         a_flush;
    logic [127:0] a_in_data;
    logic [3:0]   a_in_valid, a_in_ready;
    logic [1:0]   a_sel, a_out_ch;
    logic [31:0]  a_out_data;
    logic         a_out_valid, a_out_ready;
    // b: MODE 0, NCH 3
    logic         b_flush;
    logic [95:0]  b_in_data;
    logic [2:0]   b_in_valid, b_in_ready;
    logic [1:0]   b_sel, b_out_ch;
    logic [31:0]  b_out_data;
    logic         b_out_valid, b_out_ready;
    // c: MODE 1, NCH 4
    logic         c_flush;
    logic [127:0] c_in_data;
    logic [3:0]   c_in_valid, c_in_ready;
    logic [1:0]   c_sel, c_out_ch;
    logic [31:0]  c_out_data;
    logic         c_out_valid, c_out_ready;

    mux_n_reg #(.WIDTH(32), .NCH(4), .MODE(0)) u_a (
        .clk(clk), .rst_n(rst_n), .flush(a_flush), .in_data(a_in_data), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .sel(a_sel), .out_data(a_out_data), .out_ch(a_out_ch),
        .out_valid(a_out_valid), .out_ready(a_out_ready));
    mux_n_reg #(.WIDTH(32), .NCH(3), .MODE(0)) u_b (
        .clk(clk), .rst_n(rst_n), .flush(b_flush), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .sel(b_sel), .out_data(b_out_data), .out_ch(b_out_ch),
        .out_valid(b_out_valid), .out_ready(b_out_ready));
    mux_n_reg #(.WIDTH(32), .NCH(4), .MODE(1)) u_c (
        .clk(clk), .rst_n(rst_n), .flush(c_flush), .in_data(c_in_data), .in_valid(c_in_valid),
        .in_ready(c_in_ready), .sel(c_sel), .out_data(c_out_data), .out_ch(c_out_ch),
        .out_valid(c_out_valid), .out_ready(c_out_ready));

    int n_checks = 0;
    int n_errors = 0;
    logic [33:0] qa[$];
    logic [33:0] qc[$];
    int rr_sparse[4] = '{1, 3, 1, 3};
    int rr_full[6]   = '{0, 1, 2, 3, 0, 1};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        #1;
    endtask

    // Account for transfers seen before the edge, then advance to 1 ns past the edge.
    task automatic cycle();
        logic [33:0] e;
        if (a_out_valid && a_out_ready) begin
            if (qa.size() == 0) check("a_spurious_out", a_out_valid, 1'b0);
            else begin
                e = qa.pop_front();
                check("a_sb_data", a_out_data, e[31:0]);
                check("a_sb_ch", a_out_ch, e[33:32]);
            end
        end
        if (c_out_valid && c_out_ready) begin
            if (qc.size() == 0) check("c_spurious_out", c_out_valid, 1'b0);
            else begin
                e = qc.pop_front();
                check("c_sb_data", c_out_data, e[31:0]);
                check("c_sb_ch", c_out_ch, e[33:32]);
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (a_in_valid[k] && a_in_ready[k]) qa.push_back({2'(k), a_in_data[k*32 +: 32]});
            if (c_in_valid[k] && c_in_ready[k]) qc.push_back({2'(k), c_in_data[k*32 +: 32]});
        end
        if (a_flush) qa.delete();
        if (c_flush) qc.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        a_flush = 0; a_in_data = '0; a_in_valid = '0; a_sel = '0; a_out_ready = 1'b0;
        b_flush = 0; b_in_data = '0; b_in_valid = '0; b_sel = '0; b_out_ready = 1'b0;
        c_flush = 0; c_in_data = '0; c_in_valid = '0; c_sel = '0; c_out_ready = 1'b0;
        for (int k = 0; k < 4; k++) c_in_data[k*32 +: 32] = 32'hC000_0000 + k;

        // Reset state
        @(posedge clk); #1;
        check("rst_a_out_valid", a_out_valid, 0);
        check("rst_a_out_data", a_out_data, 0);
        check("rst_a_out_ch", a_out_ch, 0);
        check("rst_a_in_ready", a_in_ready, 0);
        check("rst_b_out_valid", b_out_valid, 0);
        check("rst_c_out_valid", c_out_valid, 0);
        check("rst_c_out_data", c_out_data, 0);
        check("rst_c_in_ready", c_in_ready, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic select, ch2
        a_in_data[2*32 +: 32] = 32'hDEAD_BEEF;
        a_sel = 2'd2; a_in_valid = 4'b0100; a_out_ready = 1'b1;
        settle();
        check("sel_in_ready", a_in_ready, 4'b0100);
        cycle();
        a_in_valid = '0;
        settle();
        check("sel_out_valid", a_out_valid, 1);
        check("sel_out_data", a_out_data, 32'hDEAD_BEEF);
        check("sel_out_ch", a_out_ch, 2);
        cycle();
        settle();
        check("sel_drained", a_out_valid, 0);

        // Out-of-range select on a 3-channel instance
        b_sel = 2'd3; b_in_valid = 3'b111; b_out_ready = 1'b1;
        b_in_data = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        for (int i = 0; i < 5; i++) begin
            settle();
            check("badsel_in_ready", b_in_ready, 0);
            check("badsel_out_valid", b_out_valid, 0);
            cycle();
        end
        b_in_valid = '0;

        // Backpressure into the skid entry
        a_sel = 2'd0; a_out_ready = 1'b0; a_in_valid = 4'b0001;
        a_in_data[31:0] = 32'h1;
        settle();
        check("bp_ready_w1", a_in_ready, 4'b0001);
        cycle();
        a_in_data[31:0] = 32'h2;
        settle();
        check("bp_ready_w2", a_in_ready, 4'b0001);
        cycle();
        a_in_data[31:0] = 32'h3;
        settle();
        check("bp_skid_full_ready", a_in_ready, 0);
        check("bp_main_data", a_out_data, 32'h1);
        cycle();
        check("bp_main_stable", a_out_data, 32'h1);
        check("bp_ch_stable", a_out_ch, 0);
        a_out_ready = 1'b1;
        settle();
        check("bp_ready_no_comb_path", a_in_ready, 0);
        cycle();
        settle();
        check("bp_ready_after_drain", a_in_ready, 4'b0001);
        cycle();
        a_in_valid = '0;
        cycle();
        settle();
        check("bp_empty", a_out_valid, 0);
        check("bp_sb_level", qa.size(), 0);

        // Round-robin: sparse then full request patterns
        c_out_ready = 1'b1;
        c_in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("rr_sparse_gnt", c_in_ready, 4'b1 << rr_sparse[i]);
            if (i > 0) check("rr_sparse_out_ch", c_out_ch, rr_sparse[i-1]);
            cycle();
        end
        c_in_valid = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            settle();
            check("rr_full_gnt", c_in_ready, 4'b1 << rr_full[i]);
            check("rr_full_out_ch", c_out_ch, (i == 0) ? 3 : rr_full[i-1]);
            cycle();
        end
        c_in_valid = '0;
        settle();
        check("rr_last_out_ch", c_out_ch, 1);
        cycle();

        // Flush with main and skid both full
        c_out_ready = 1'b0; c_in_valid = 4'b1111;
        settle();
        check("fl_gnt_main", c_in_ready, 4'b0100);
        cycle();
        settle();
        check("fl_gnt_skid", c_in_ready, 4'b1000);
        cycle();
        settle();
        check("fl_full_ready", c_in_ready, 0);
        c_flush = 1'b1;
        settle();
        check("fl_during_ready", c_in_ready, 0);
        cycle();
        c_flush = 1'b0;
        settle();
        check("fl_out_valid", c_out_valid, 0);
        check("fl_ptr_reset", c_in_ready, 4'b0001);
        c_out_ready = 1'b1;
        cycle();
        c_in_valid = '0;
        settle();
        check("fl_resume_valid", c_out_valid, 1);
        check("fl_resume_ch", c_out_ch, 0);
        check("fl_resume_data", c_out_data, 32'hC000_0000);
        cycle();

        // Asynchronous reset between edges
        c_out_ready = 1'b0; c_in_valid = 4'b0001;
        cycle();
        c_in_valid = 4'b1111;
        settle();
        check("ar_pre_valid", c_out_valid, 1);
        check("ar_pre_ready", c_in_ready, 4'b0010);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_out_valid", c_out_valid, 0);
        check("ar_in_ready", c_in_ready, 0);
        check("ar_out_data", c_out_data, 0);
        check("ar_out_ch", c_out_ch, 0);
        qa.delete();
        qc.delete();
        c_in_valid = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        settle();
        check("ar_post_valid", c_out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
